// File: rtl/edge_detector_sequencer_pkg.sv
// Shared types and defaults for the edge-detector sequencer: FSM state
// encoding, image geometry and pixel width.
package edge_detector_pkg;

  localparam int PIX_W       = 8;
  localparam int PIX_CNT_DEF = 64;
  localparam int OUT_CNT_DEF = 36;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START_HI = 4'd1,
    S_START_LO = 4'd2,
    S_RD       = 4'd3,
    S_PUSH     = 4'd4,
    S_WAIT_IN  = 4'd5,
    S_WAIT_RES = 4'd6,
    S_WR       = 4'd7,
    S_NEXT_OUT = 4'd8,
    S_FIN      = 4'd9
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detector_sequencer_if.sv
// Avalon-MM master bus plus edge-detector core control/data ports, bundled
// so the sequencer sees one master-side view and the system one slave-side view.
interface edge_detector_sequencer_if
  import edge_detector_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  logic              eng_start;
  logic [PIX_W-1:0]  eng_pix;
  logic              eng_pix_wr;
  logic              eng_in_done;
  logic              eng_data_avail;
  logic [PIX_W-1:0]  eng_out_pix;
  logic              eng_out_rd;
  logic              eng_out_done;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    output eng_start, eng_pix, eng_pix_wr, eng_out_rd,
    input  avm_readdata, avm_waitrequest,
    input  eng_in_done, eng_data_avail, eng_out_pix, eng_out_done
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    input  eng_start, eng_pix, eng_pix_wr, eng_out_rd,
    output avm_readdata, avm_waitrequest,
    output eng_in_done, eng_data_avail, eng_out_pix, eng_out_done
  );
endinterface

// File: rtl/edge_detector_sequencer_watchdog.sv
// Loadable down-counter used to bound waits on core status; expire_o is high
// whenever the count sits at zero.
module edge_seq_watchdog #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear beats load beats count-down; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/edge_detector_sequencer.sv
// Avalon-MM master that feeds one image into the edge-detector core and
// drains its result back to memory, with a watchdog on every core-status wait.
module edge_detector_sequencer
  import edge_detector_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int PIX_CNT = PIX_CNT_DEF,
  parameter int OUT_CNT = OUT_CNT_DEF,
  parameter int TIMEOUT = 4095
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDR_W-1:0]         src_addr_i,
  input  logic [ADDR_W-1:0]         dst_addr_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  edge_detector_sequencer_if.master bus
);
  localparam int MAX_CNT = max_int(PIX_CNT, OUT_CNT);
  localparam int IDX_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(PIX_CNT - 1);
  localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(OUT_CNT - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              eng_start_q, eng_start_d;
  logic              pix_wr_q, pix_wr_d;
  logic              out_rd_q, out_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              wd_clr_s, wd_load_s, wd_en_s, wd_expire_s;
  logic              unused_rdata_s;

  function automatic logic [ADDR_W-1:0] word_off(input logic [IDX_W-1:0] i);
    return ADDR_W'({i, 2'b00});
  endfunction

  // Next-state, index, latches and watchdog control.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    src_d     = src_q;
    dst_d     = dst_q;
    pix_d     = pix_q;
    done_d    = 1'b0;
    error_d   = error_q;
    wd_load_s = 1'b0;
    wd_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q marks the cycle right after completion: a start there is dropped.
        if (start_i && !done_q) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = S_START_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START_HI: state_d = S_START_LO;
      S_START_LO: state_d = S_RD;
      S_RD: begin
        if (!bus.avm_waitrequest) begin
          pix_d   = bus.avm_readdata[PIX_W-1:0];
          state_d = S_PUSH;
        end else begin
          state_d = S_RD;
        end
      end
      S_PUSH: begin
        if (idx_q == PIX_LAST) begin
          idx_d     = '0;
          wd_load_s = 1'b1;
          state_d   = S_WAIT_IN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_RD;
        end
      end
      S_WAIT_IN: begin
        if (bus.eng_in_done) begin
          wd_load_s = 1'b1;
          state_d   = S_WAIT_RES;
        end else if (wd_expire_s) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          wd_en_s = 1'b1;
        end
      end
      S_WAIT_RES: begin
        if (bus.eng_data_avail) begin
          state_d = S_WR;
        end else if (wd_expire_s) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          wd_en_s = 1'b1;
        end
      end
      S_WR: begin
        if (!bus.avm_waitrequest) begin
          state_d = S_NEXT_OUT;
        end else begin
          state_d = S_WR;
        end
      end
      S_NEXT_OUT: begin
        if (idx_q == OUT_LAST) begin
          idx_d     = '0;
          wd_load_s = 1'b1;
          state_d   = S_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_WR;
        end
      end
      S_FIN: begin
        if (bus.eng_out_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wd_expire_s) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          wd_en_s = 1'b1;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered Moore outputs decoded from the upcoming state.
  always_comb begin
    wd_clr_s    = (state_d == S_IDLE);
    rd_d        = (state_d == S_RD);
    wr_d        = (state_d == S_WR);
    eng_start_d = (state_d == S_START_HI);
    pix_wr_d    = (state_d == S_PUSH);
    out_rd_d    = (state_d == S_NEXT_OUT);
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_RD:    addr_d = src_d + word_off(idx_d);
      S_WR:    addr_d = dst_d + word_off(idx_d);
      default: addr_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      pix_q       <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      eng_start_q <= 1'b0;
      pix_wr_q    <= 1'b0;
      out_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      pix_q       <= pix_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      eng_start_q <= eng_start_d;
      pix_wr_q    <= pix_wr_d;
      out_rd_q    <= out_rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  edge_seq_watchdog #(.W(WD_W)) u_watchdog (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (wd_clr_s),
    .load_i     (wd_load_s),
    .load_val_i (WD_LOAD),
    .en_i       (wd_en_s),
    .expire_o   (wd_expire_s)
  );

  // The core holds its result pixel until eng_out_rd, so the write data is
  // taken straight from it while the write strobe is up.
  assign bus.avm_writedata = wr_q ? {{(32-PIX_W){1'b0}}, bus.eng_out_pix} : 32'h0000_0000;
  assign bus.avm_address   = addr_q;
  assign bus.avm_read      = rd_q;
  assign bus.avm_write     = wr_q;
  assign bus.eng_start     = eng_start_q;
  assign bus.eng_pix       = pix_q;
  assign bus.eng_pix_wr    = pix_wr_q;
  assign bus.eng_out_rd    = out_rd_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign error_o           = error_q;
  assign unused_rdata_s    = ^bus.avm_readdata[31:PIX_W];
endmodule

// File: tb/tb_edge_detector_sequencer.sv
// Directed bench: memory and core models on the slave side of the interface,
// hand-computed expectations for addresses, pixels, results and flags.
module tb_edge_detector_sequencer;
  import edge_detector_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src, dst;
  logic        busy, done, error;

  always #5 clk = ~clk;

  edge_detector_sequencer_if #(.ADDR_W(32)) bus ();

  edge_detector_sequencer #(
    .ADDR_W(32), .PIX_CNT(64), .OUT_CNT(36), .TIMEOUT(100)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .src_addr_i(src), .dst_addr_i(dst),
    .busy_o(busy), .done_o(done), .error_o(error),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] out_f(input int k);
    return 8'(k * 3 + 7);
  endfunction

  // Memory: pixel = word index within a 1 KiB window, upper bits are junk.
  assign bus.avm_readdata = {24'hA5A5A5, bus.avm_address[9:2]};

  int  cyc = 0;
  always @(posedge clk) cyc++;

  int  stall_max = 0;
  bit  force_stall = 1'b0;
  bit  avail_en = 1'b1;
  int  stall_left, in_cnt, out_idx, avail_dly;
  bit  in_flight, prev_stalled;
  logic        prev_rd, prev_wr, prev_start;
  logic [31:0] prev_addr, prev_wdata;
  int  stab_viol = 0, conc_viol = 0, done_cnt = 0, last_push_cyc = 0, done_cyc = 0;
  logic [31:0] rd_addr_log[$];
  int          rd_cyc_log[$];
  logic [7:0]  pix_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  // Slave-side models, all acting mid-cycle so the DUT sees settled inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.avm_waitrequest = 1'b0;
      bus.eng_in_done = 1'b0; bus.eng_data_avail = 1'b0; bus.eng_out_done = 1'b0;
      bus.eng_out_pix = out_f(0);
      in_flight = 1'b0; stall_left = 0; prev_stalled = 1'b0; prev_start = 1'b0;
      in_cnt = 0; out_idx = 0; avail_dly = 0;
    end else begin
      if (bus.avm_read && bus.avm_write) conc_viol++;
      if (prev_stalled && (bus.avm_read !== prev_rd || bus.avm_write !== prev_wr ||
          bus.avm_address !== prev_addr || bus.avm_writedata !== prev_wdata)) stab_viol++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (bus.avm_read || bus.avm_write) begin
        if (!in_flight) begin
          in_flight = 1'b1;
          stall_left = $urandom_range(stall_max, 0);
        end else if (stall_left > 0) begin
          stall_left--;
        end
      end else begin
        in_flight = 1'b0;
        stall_left = 0;
      end
      bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (force_stall || stall_left != 0);
      if (bus.avm_read && !bus.avm_waitrequest) begin
        rd_addr_log.push_back(bus.avm_address);
        rd_cyc_log.push_back(cyc);
      end
      if (bus.avm_write && !bus.avm_waitrequest) begin
        wr_addr_log.push_back(bus.avm_address);
        wr_data_log.push_back(bus.avm_writedata);
      end
      prev_stalled = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
      prev_rd = bus.avm_read; prev_wr = bus.avm_write;
      prev_addr = bus.avm_address; prev_wdata = bus.avm_writedata;
      if (prev_start && !bus.eng_start) begin
        in_cnt = 0; out_idx = 0; avail_dly = 0;
        bus.eng_in_done = 1'b0; bus.eng_data_avail = 1'b0; bus.eng_out_done = 1'b0;
      end
      prev_start = bus.eng_start;
      if (bus.eng_pix_wr) begin
        pix_log.push_back(bus.eng_pix);
        in_cnt++;
        last_push_cyc = cyc;
        if (in_cnt == 64) bus.eng_in_done = 1'b1;
      end
      if (bus.eng_in_done && avail_en && !bus.eng_data_avail) begin
        avail_dly++;
        if (avail_dly >= 5) bus.eng_data_avail = 1'b1;
      end
      if (bus.eng_out_rd) begin
        out_idx++;
        if (out_idx == 36) bus.eng_out_done = 1'b1;
      end
      bus.eng_out_pix = out_f(out_idx);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_read"}, 32'(bus.avm_read), 32'd0);
    check({tag, "_write"}, 32'(bus.avm_write), 32'd0);
    check({tag, "_addr"}, bus.avm_address, 32'd0);
    check({tag, "_wdata"}, bus.avm_writedata, 32'd0);
    check({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
    check({tag, "_eng_pix"}, 32'(bus.eng_pix), 32'd0);
    check({tag, "_pix_wr"}, 32'(bus.eng_pix_wr), 32'd0);
    check({tag, "_out_rd"}, 32'(bus.eng_out_rd), 32'd0);
  endtask

  task automatic send_start(input logic [31:0] s, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; src = s; dst = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_reads(input string tag, input int rb, input int n);
    int k = 0;
    while ((rd_addr_log.size() - rb) < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_reads_reached"}, 32'((rd_addr_log.size() - rb) >= n), 32'd1);
  endtask

  task automatic check_image(input string tag, input logic [31:0] s, input logic [31:0] d,
                             input int rb, input int pb, input int wb, input int db);
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check({tag, "_done_width"}, 32'(done_cnt - db), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_rd_count"}, 32'(rd_addr_log.size() - rb), 32'd64);
    check({tag, "_pix_count"}, 32'(pix_log.size() - pb), 32'd64);
    check({tag, "_wr_count"}, 32'(wr_addr_log.size() - wb), 32'd36);
    for (int i = 0; i < 64; i++) begin
      a = s + 32'(4 * i);
      if (rb + i < rd_addr_log.size()) check({tag, "_rd_addr"}, rd_addr_log[rb + i], a);
      if (pb + i < pix_log.size()) check({tag, "_pix"}, {24'h0, pix_log[pb + i]}, {24'h0, a[9:2]});
    end
    for (int k = 0; k < 36; k++) begin
      if (wb + k < wr_addr_log.size()) begin
        check({tag, "_wr_addr"}, wr_addr_log[wb + k], d + 32'(4 * k));
        check({tag, "_wr_data"}, wr_data_log[wb + k], {24'h0, out_f(k)});
      end
    end
  endtask

  int rb, pb, wb, db;

  task automatic snap();
    rb = rd_addr_log.size(); pb = pix_log.size(); wb = wr_addr_log.size(); db = done_cnt;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src = 32'h0; dst = 32'h0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal run with start-handshake timing.
    snap();
    send_start(32'h0000_1000, 32'h0000_2000);
    check("t1_eng_start_hi", 32'(bus.eng_start), 32'd1);
    check("t1_busy_hi", 32'(busy), 32'd1);
    check("t1_no_read_c1", 32'(bus.avm_read), 32'd0);
    @(negedge clk);
    check("t1_eng_start_lo", 32'(bus.eng_start), 32'd0);
    check("t1_no_read_c2", 32'(bus.avm_read), 32'd0);
    @(negedge clk);
    check("t1_first_read", 32'(bus.avm_read), 32'd1);
    check("t1_first_addr", bus.avm_address, 32'h0000_1000);
    wait_done("t1");
    check_image("t1", 32'h0000_1000, 32'h0000_2000, rb, pb, wb, db);
    if (rb + 63 < rd_cyc_log.size())
      check("t1_read_span", 32'(rd_cyc_log[rb + 63] - rd_cyc_log[rb]), 32'd126);

    // Waitrequest stress.
    stall_max = 5;
    snap();
    send_start(32'h0000_1000, 32'h0000_2000);
    wait_done("t2");
    check_image("t2", 32'h0000_1000, 32'h0000_2000, rb, pb, wb, db);
    stall_max = 0;

    // Timeout: the core never offers a result.
    avail_en = 1'b0;
    snap();
    send_start(32'h0000_1000, 32'h0000_2000);
    wait_done("t3");
    repeat (3) @(negedge clk);
    check("t3_error_set", 32'(error), 32'd1);
    check("t3_done_width", 32'(done_cnt - db), 32'd1);
    check("t3_no_writes", 32'(wr_addr_log.size() - wb), 32'd0);
    check("t3_timeout_latency", 32'(done_cyc - last_push_cyc), 32'd102);
    avail_en = 1'b1;
    snap();
    send_start(32'h0000_1000, 32'h0000_2000);
    check("t3_error_cleared", 32'(error), 32'd0);
    wait_done("t3b");
    check_image("t3b", 32'h0000_1000, 32'h0000_2000, rb, pb, wb, db);

    // Start mid-image and on the done cycle are both ignored.
    snap();
    send_start(32'h0000_1000, 32'h0000_2000);
    wait_reads("t4", rb, 20);
    @(negedge clk);
    start = 1'b1; src = 32'h0000_5000; dst = 32'h0000_6000;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4");
    start = 1'b1; src = 32'h0000_7000; dst = 32'h0000_8000;
    @(negedge clk);
    start = 1'b0;
    check("t4_done_cycle_start_busy", 32'(busy), 32'd0);
    check("t4_done_cycle_start_eng", 32'(bus.eng_start), 32'd0);
    check_image("t4", 32'h0000_1000, 32'h0000_2000, rb, pb, wb, db);

    // Reset during a stalled read, then a clean image.
    snap();
    send_start(32'h0000_1000, 32'h0000_2000);
    wait_reads("t5", rb, 10);
    force_stall = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_read_stalled", 32'(bus.avm_read), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("t5_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    force_stall = 1'b0;
    @(negedge clk);
    check_outputs_zero("t5_after");
    check("t5_no_done", 32'(done_cnt - db), 32'd0);
    snap();
    send_start(32'h0000_1000, 32'h0000_2000);
    wait_done("t5b");
    check_image("t5b", 32'h0000_1000, 32'h0000_2000, rb, pb, wb, db);

    // Source address wraps through zero.
    snap();
    send_start(32'hFFFF_FFF0, 32'h0000_3000);
    wait_done("t6");
    check_image("t6", 32'hFFFF_FFF0, 32'h0000_3000, rb, pb, wb, db);
    if (rb + 4 < rd_addr_log.size()) begin
      check("t6_addr3", rd_addr_log[rb + 3], 32'hFFFF_FFFC);
      check("t6_addr4_wrapped", rd_addr_log[rb + 4], 32'h0000_0000);
    end

    check("bus_stable_in_stall", 32'(stab_viol), 32'd0);
    check("no_concurrent_rw", 32'(conc_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
